io_uart: RTL and testbench

Memory-mapped UART peripheral on the processor's IO bus: the datapath's address decoder forwards IO-region loads/stores here. It serialises stored bytes onto `tx` (8N1, LSB first) through a 4-entry TX FIFO. It also deserialises `rx` into a one-byte receive buffer with an overrun flag. Reads are combinational so the single-cycle core can consume `io_read_value` in the same cycle; all side effects commit on the rising clock edge.

---
 rtl/io_uart.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_io_uart.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart.sv
// ---------------------------------------------------------------------------
// io_uart
//
// Memory-mapped UART peripheral on the processor IO bus. Stored bytes are
// queued in a 4-entry TX FIFO and serialised 8N1, LSB first, on tx. Bytes
// arriving on rx are deserialised into a one-byte receive buffer with a
// valid flag and an overrun flag. Loads are combinational so a single-cycle
// core can consume io_read_value in the cycle it presents the address. All
// side effects commit on the rising clock edge.
//
// Register map (selected when io_address[31:3] == BASE_ADDR[31:3]):
//   io_address[2] = 0  DATA    read : {24'b0, rx_data}, clears rx_valid
//                              write: push io_write_value[7:0] into TX FIFO
//   io_address[2] = 1  STATUS  read : {28'b0, rx_overrun, rx_valid,
//                                     tx_empty, tx_full}
//                              write: io_write_value[3] = 1 clears rx_overrun
//
// Ports:
//   clk             in   1   sole clock, rising edge
//   reset_n         in   1   synchronous active-low reset
//   io_address      in  32   byte address from the decoder
//   io_write_value  in  32   store data
//   io_write_en     in   1   store strobe
//   io_read_en      in   1   load strobe
//   io_data_size    in   3   access size, ignored (word access assumed)
//   io_read_value   out 32   combinational load data, 0 when not selected
//   tx              out  1   serial output, idles high
//   rx              in   1   asynchronous serial input
// ---------------------------------------------------------------------------
module io_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [2:0]  io_data_size,
  output logic [31:0] io_read_value,
  output logic        tx,
  input  logic        rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } UartState;

  // Bus decode
  logic w_sel;
  logic w_dataWr;
  logic w_dataRd;
  logic w_statWr;

  assign w_sel    = (io_address[31:3] == BASE_ADDR[31:3]);
  assign w_dataWr = w_sel && io_write_en && !io_address[2];
  assign w_dataRd = w_sel && io_read_en  && !io_address[2];
  assign w_statWr = w_sel && io_write_en &&  io_address[2];

  // Only the low byte (DATA) and bit 3 (STATUS) of the store data matter,
  // and the access size is irrelevant for this block.
  logic w_unused;
  assign w_unused = ^{io_data_size, io_write_value[31:8], io_address[1:0]};

  // TX FIFO storage and bookkeeping
  logic [7:0] r_txFifo [4];
  logic [1:0] r_txWrPtr;
  logic [1:0] r_txRdPtr;
  logic [2:0] r_txCount;
  logic       w_txFull;
  logic       w_push;
  logic       w_pop;

  // Fullness is judged on the count before any same-cycle pop, so a write
  // into a full FIFO is dropped even while the transmitter is draining it.
  assign w_txFull = (r_txCount == 3'd4);
  assign w_push   = w_dataWr && !w_txFull;

  // FIFO pointers wrap naturally at 2 bits; a push and pop together leave
  // the count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_txWrPtr <= 2'd0;
      r_txRdPtr <= 2'd0;
      r_txCount <= 3'd0;
    end else begin
      if (w_push) begin
        r_txFifo[r_txWrPtr] <= io_write_value[7:0];
        r_txWrPtr           <= r_txWrPtr + 2'd1;
      end
      if (w_pop) begin
        r_txRdPtr <= r_txRdPtr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_txCount <= r_txCount + 3'd1;
        2'b01:   r_txCount <= r_txCount - 3'd1;
        default: r_txCount <= r_txCount;
      endcase
    end
  end

  // TX serialiser
  UartState      r_txState;
  UartState      w_txStateNext;
  logic [CW-1:0] r_txCnt;
  logic [CW-1:0] w_txCntNext;
  logic [2:0]    r_txBit;
  logic [2:0]    w_txBitNext;
  logic [7:0]    r_txShift;
  logic [7:0]    w_txShiftNext;
  logic          w_tx;
  logic          w_txEmpty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_txState <= S_IDLE;
      r_txCnt   <= '0;
      r_txBit   <= 3'd0;
      r_txShift <= 8'd0;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txBit   <= w_txBitNext;
      r_txShift <= w_txShiftNext;
    end
  end

  // Leaving STOP always passes through IDLE for one cycle, which gives the
  // single idle-high cycle between back-to-back frames.
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
    w_pop         = 1'b0;
    w_tx          = 1'b1;
    case (r_txState)
      S_IDLE: begin
        if (r_txCount != 3'd0) begin
          w_pop         = 1'b1;
          w_txShiftNext = r_txFifo[r_txRdPtr];
          w_txCntNext   = '0;
          w_txStateNext = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext   = '0;
          w_txBitNext   = 3'd0;
          w_txStateNext = S_DATA;
        end else begin
          w_txCntNext = r_txCnt + CNT_ONE;
        end
      end
      S_DATA: begin
        w_tx = r_txShift[0];
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext   = '0;
          w_txShiftNext = {1'b0, r_txShift[7:1]};
          if (r_txBit == 3'd7) begin
            w_txStateNext = S_STOP;
          end else begin
            w_txBitNext = r_txBit + 3'd1;
          end
        end else begin
          w_txCntNext = r_txCnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext   = '0;
          w_txStateNext = S_IDLE;
        end else begin
          w_txCntNext = r_txCnt + CNT_ONE;
        end
      end
      default: begin
        w_txStateNext = S_IDLE;
      end
    endcase
  end

  assign tx        = w_tx;
  assign w_txEmpty = (r_txCount == 3'd0) && (r_txState == S_IDLE);

  // RX input synchroniser; resets to the idle-high line level so no false
  // start bit is seen coming out of reset.
  logic r_rxMeta;
  logic r_rxSync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // RX deserialiser
  UartState      r_rxState;
  UartState      w_rxStateNext;
  logic [CW-1:0] r_rxCnt;
  logic [CW-1:0] w_rxCntNext;
  logic [2:0]    r_rxBit;
  logic [2:0]    w_rxBitNext;
  logic [7:0]    r_rxShift;
  logic [7:0]    w_rxShiftNext;
  logic          w_rxDone;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rxState <= S_IDLE;
      r_rxCnt   <= '0;
      r_rxBit   <= 3'd0;
      r_rxShift <= 8'd0;
    end else begin
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      r_rxShift <= w_rxShiftNext;
    end
  end

  // START waits half a bit so that every later sample lands mid-bit.
  // w_rxDone pulses only for a frame whose stop bit samples high.
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt;
    w_rxBitNext   = r_rxBit;
    w_rxShiftNext = r_rxShift;
    w_rxDone      = 1'b0;
    case (r_rxState)
      S_IDLE: begin
        if (!r_rxSync) begin
          w_rxCntNext   = '0;
          w_rxStateNext = S_START;
        end
      end
      S_START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntNext   = '0;
          w_rxBitNext   = 3'd0;
          w_rxStateNext = r_rxSync ? S_IDLE : S_DATA;
        end else begin
          w_rxCntNext = r_rxCnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {r_rxSync, r_rxShift[7:1]};
          if (r_rxBit == 3'd7) begin
            w_rxStateNext = S_STOP;
          end else begin
            w_rxBitNext = r_rxBit + 3'd1;
          end
        end else begin
          w_rxCntNext = r_rxCnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxDone      = r_rxSync;
          w_rxStateNext = S_IDLE;
        end else begin
          w_rxCntNext = r_rxCnt + CNT_ONE;
        end
      end
      default: begin
        w_rxStateNext = S_IDLE;
      end
    endcase
  end

  // Receive buffer. A DATA read in the same cycle as a new byte frees the
  // buffer, so the new byte loads without an overrun. Overrun set takes
  // priority over a same-cycle STATUS clear.
  logic [7:0] r_rxData;
  logic       r_rxValid;
  logic       r_rxOverrun;
  logic       w_rxHeld;

  assign w_rxHeld = r_rxValid && !w_dataRd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rxData    <= 8'd0;
      r_rxValid   <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else begin
      if (w_rxDone && !w_rxHeld) begin
        r_rxData  <= r_rxShift;
        r_rxValid <= 1'b1;
      end else if (w_dataRd) begin
        r_rxValid <= 1'b0;
      end
      if (w_rxDone && w_rxHeld) begin
        r_rxOverrun <= 1'b1;
      end else if (w_statWr && io_write_value[3]) begin
        r_rxOverrun <= 1'b0;
      end
    end
  end

  // Combinational load data
  always_comb begin
    io_read_value = 32'd0;
    if (w_sel) begin
      if (io_address[2]) begin
        io_read_value = {28'd0, r_rxOverrun, r_rxValid, w_txEmpty, w_txFull};
      end else begin
        io_read_value = {24'd0, r_rxData};
      end
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// ---------------------------------------------------------------------------
// tb_io_uart
//
// Self-checking bench for io_uart with CLKS_PER_BIT = 8. Transmitted frames
// are recorded one sample per clock and compared against ideal 8N1
// waveforms built from the byte values. Received bytes are tracked by a
// small model of the receive buffer (data, valid, overrun).
// ---------------------------------------------------------------------------
module tb_io_uart;

  localparam int          CPB       = 8;
  localparam int          FRAME     = 10 * CPB;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] DATA_ADDR = BASE;
  localparam logic [31:0] STAT_ADDR = BASE + 32'd4;
  // Valid should rise 2 + 9.5 bit times after the start edge, +/- 1 cycle,
  // with one more cycle allowed for where the bench samples.
  localparam int LAT_LO = 2 + (19 * CPB) / 2 - 1;
  localparam int LAT_HI = 2 + (19 * CPB) / 2 + 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;
  logic [31:0] io_read_value;
  logic        tx;
  logic        rx;

  int   vecCount = 0;
  int   errCount = 0;
  logic rxLevel  = 1'b1;
  logic txCapture = 1'b0;
  logic txLog [$];

  // Receive buffer model
  logic [7:0] expData    = 8'd0;
  logic       expValid   = 1'b0;
  logic       expOverrun = 1'b0;

  always #5 clk = ~clk;

  io_uart #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io_address     (io_address),
    .io_write_value (io_write_value),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_data_size   (io_data_size),
    .io_read_value  (io_read_value),
    .tx             (tx),
    .rx             (rx)
  );

  // Record the serial line once per cycle while capture is on
  always @(negedge clk) begin
    if (txCapture) txLog.push_back(tx);
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, let the read path settle
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk);
    rx             = rxLevel;
    io_write_en    = wr;
    io_read_en     = rd;
    io_address     = {addr[31:2], 2'($urandom_range(3, 0))};
    io_write_value = wdata;
    io_data_size   = 3'($urandom_range(7, 0));
    #1;
  endtask

  function automatic logic [31:0] expStatus(input logic txEmpty, input logic txFull);
    return {28'd0, expOverrun, expValid, txEmpty, txFull};
  endfunction

  // Ideal line level for one frame followed by one idle cycle
  function automatic logic [127:0] frameWave(input logic [7:0] b);
    logic [127:0] w;
    int bitIdx;
    w = '0;
    for (int k = 0; k < FRAME; k++) begin
      bitIdx = k / CPB;
      if (bitIdx == 0)      w[k] = 1'b0;
      else if (bitIdx <= 8) w[k] = b[bitIdx - 1];
      else                  w[k] = 1'b1;
    end
    w[FRAME] = 1'b1;
    return w;
  endfunction

  function automatic logic [127:0] logSlice(input int start);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k <= FRAME; k++) begin
      w[k] = (start + k < txLog.size()) ? txLog[start + k] : 1'bx;
    end
    return w;
  endfunction

  function automatic int zerosFrom(input int start);
    int z;
    z = 0;
    for (int k = start; k < txLog.size(); k++) begin
      if (txLog[k] !== 1'b1) z++;
    end
    return z;
  endfunction

  task automatic txSingle(input logic [7:0] b);
    txLog.delete();
    applyStimulus(1'b1, 1'b0, DATA_ADDR, {24'($urandom), b});
    txCapture = 1'b1;
    for (int n = 0; n <= FRAME + 1; n++) begin
      applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
      if (n == FRAME)     checkOutput("txBusyInStop", 128'(io_read_value), 128'(expStatus(1'b0, 1'b0)));
      if (n == FRAME + 1) checkOutput("txEmptyAfter", 128'(io_read_value), 128'(expStatus(1'b1, 1'b0)));
    end
    txCapture = 1'b0;
    checkOutput("txIdleBeforeStart", 128'(txLog[0]), 128'(1'b1));
    checkOutput($sformatf("txWave_%02h", b), logSlice(1), frameWave(b));
  endtask

  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    logic       wasValid;
    int         riseAt;
    frame    = {stopBit, b, 1'b0};
    wasValid = expValid;
    riseAt   = -1;
    for (int n = 0; n < 12 * CPB; n++) begin
      rxLevel = (n < FRAME) ? frame[n / CPB] : 1'b1;
      applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
      if (riseAt < 0 && !wasValid && io_read_value[2]) riseAt = n;
    end
    if (stopBit) begin
      if (!expValid) begin
        expData  = b;
        expValid = 1'b1;
        checkOutput("rxLatency", 128'(riseAt >= LAT_LO && riseAt <= LAT_HI), 128'(1'b1));
      end else begin
        expOverrun = 1'b1;
      end
    end
    checkOutput($sformatf("rxStatus_%02h_%0b", b, stopBit), 128'(io_read_value),
                128'(expStatus(1'b1, 1'b0)));
  endtask

  task automatic readData();
    applyStimulus(1'b0, 1'b1, DATA_ADDR, 32'd0);
    checkOutput("rxData", 128'(io_read_value), 128'({24'd0, expData}));
    expValid = 1'b0;
    applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    checkOutput("rxValidCleared", 128'(io_read_value), 128'(expStatus(1'b1, 1'b0)));
  endtask

  task automatic writeStatus(input logic [31:0] v);
    applyStimulus(1'b1, 1'b0, STAT_ADDR, v);
    if (v[3]) expOverrun = 1'b0;
    applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    checkOutput("statusWrite", 128'(io_read_value), 128'(expStatus(1'b1, 1'b0)));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] acc [$];
    int         occ;
    logic [7:0] b;
    logic       doRead;

    reset_n        = 1'b0;
    rx             = 1'b1;
    io_address     = 32'd0;
    io_write_value = 32'd0;
    io_write_en    = 1'b0;
    io_read_en     = 1'b0;
    io_data_size   = 3'd0;

    // Reset and post-reset register values
    repeat (3) applyStimulus(1'b0, 1'b0, DATA_ADDR, 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    checkOutput("resetStatus", 128'(io_read_value), 128'(32'h2));
    checkOutput("resetTx", 128'(tx), 128'(1'b1));
    applyStimulus(1'b0, 1'b1, DATA_ADDR, 32'd0);
    checkOutput("resetData", 128'(io_read_value), 128'(32'h0));

    // Single TX frames: directed then random bytes
    txSingle(8'hA5);
    for (int i = 0; i < 3; i++) txSingle(8'($urandom));

    // Burst of six writes on consecutive cycles. The first byte leaves the
    // FIFO for the shifter straight away, so four more fit and the sixth
    // arrives while the FIFO holds four.
    txLog.delete();
    acc.delete();
    for (int i = 0; i < 6; i++) begin
      occ = (i <= 1) ? acc.size() : acc.size() - 1;
      if (occ < 4) acc.push_back(8'(i + 1));
      applyStimulus(1'b1, 1'b0, DATA_ADDR, 32'(i + 1));
      if (i == 0) txCapture = 1'b1;
    end
    applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    checkOutput("txFullFlag", 128'(io_read_value), 128'(expStatus(1'b0, 1'b1)));
    repeat (5 * (FRAME + 1) + 95) applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    txCapture = 1'b0;
    for (int j = 0; j < acc.size(); j++) begin
      checkOutput($sformatf("txBurst%0d", j), logSlice(1 + j * (FRAME + 1)), frameWave(acc[j]));
    end
    checkOutput("txBurstNoExtra", 128'(zerosFrom(1 + acc.size() * (FRAME + 1))), 128'(0));
    checkOutput("txBurstDrained", 128'(io_read_value), 128'(expStatus(1'b1, 1'b0)));

    // Accesses outside the block's window
    applyStimulus(1'b0, 1'b1, 32'h0000_2004, 32'd0);
    checkOutput("unselReadFar", 128'(io_read_value), 128'(32'd0));
    applyStimulus(1'b0, 1'b1, BASE + 32'd8, 32'd0);
    checkOutput("unselReadNear", 128'(io_read_value), 128'(32'd0));
    txLog.delete();
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h55);
    txCapture = 1'b1;
    applyStimulus(1'b1, 1'b0, BASE + 32'd8, 32'h55);
    repeat (100) applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    txCapture = 1'b0;
    checkOutput("unselNoFrame", 128'(zerosFrom(0)), 128'(0));
    checkOutput("unselStatus", 128'(io_read_value), 128'(expStatus(1'b1, 1'b0)));

    // RX byte, read, valid clears
    sendRx(8'h3C, 1'b1);
    readData();

    // Overrun, keep first byte, clear via STATUS
    sendRx(8'h11, 1'b1);
    sendRx(8'h22, 1'b1);
    readData();
    writeStatus(32'h0000_0007);
    writeStatus(32'h0000_0008);

    // Short glitch is not a start bit
    rxLevel = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    rxLevel = 1'b1;
    repeat (2 * CPB) applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    checkOutput("rxGlitch", 128'(io_read_value), 128'(expStatus(1'b1, 1'b0)));

    // Framing error discards the byte
    sendRx(8'($urandom), 1'b0);

    // Random receive traffic against the buffer model
    for (int i = 0; i < 8; i++) begin
      b      = 8'($urandom);
      doRead = 1'($urandom_range(1, 0));
      sendRx(b, ($urandom_range(3, 0) != 0));
      if (doRead) readData();
      if ($urandom_range(2, 0) == 0) writeStatus($urandom & 32'hF);
    end

    // Reset in the middle of a frame with bytes still queued and an unread
    // received byte.
    sendRx(8'($urandom), 1'b1);
    applyStimulus(1'b1, 1'b0, DATA_ADDR, 32'h00);
    applyStimulus(1'b1, 1'b0, DATA_ADDR, 32'h0F);
    applyStimulus(1'b1, 1'b0, DATA_ADDR, 32'hF0);
    repeat (18) applyStimulus(1'b0, 1'b0, DATA_ADDR, 32'd0);
    checkOutput("txMidFrame", 128'(tx), 128'(1'b0));
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, STAT_ADDR, 32'd0);
    expValid   = 1'b0;
    expOverrun = 1'b0;
    expData    = 8'd0;
    checkOutput("abortTx", 128'(tx), 128'(1'b1));
    checkOutput("abortStatus", 128'(io_read_value), 128'(32'h2));
    reset_n = 1'b1;
    txLog.delete();
    txCapture = 1'b1;
    repeat (FRAME + 20) applyStimulus(1'b0, 1'b0, DATA_ADDR, 32'd0);
    txCapture = 1'b0;
    checkOutput("abortFifoLost", 128'(zerosFrom(0)), 128'(0));
    applyStimulus(1'b0, 1'b1, DATA_ADDR, 32'd0);
    checkOutput("abortData", 128'(io_read_value), 128'(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
